// File: rtl/ctrl_update_queue_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_update_queue_pkg
//   Shared types for the control-update queue.
//   - SIZE_PC / BRANCH_TYPE / SIZE_CTI_LOG : core-wide field widths
//   - ctrlUpdPkt        : one resolved control-transfer result
//   - CTRL_UPD_PKT_SIZE : packed width of ctrlUpdPkt (FIFO word width)
// ---------------------------------------------------------------------------
package ctrl_update_queue_pkg;

  localparam int SIZE_PC      = 32;
  localparam int BRANCH_TYPE  = 2;
  localparam int SIZE_CTI_LOG = 4;

  typedef struct packed {
    logic [SIZE_PC-1:0]      pc;
    logic [BRANCH_TYPE-1:0]  ctrlType;
    logic [SIZE_PC-1:0]      nextPC;
    logic                    ctrlDir;
    logic [SIZE_CTI_LOG-1:0] ctiID;
  } ctrlUpdPkt;

  localparam int CTRL_UPD_PKT_SIZE = $bits(ctrlUpdPkt);

endpackage

// File: rtl/ctrl_update_queue_fifo_ram.sv
// ---------------------------------------------------------------------------
// ctrl_upd_fifo_ram
//   DEPTH x WIDTH register array backing the control-update queue.
//   Ports:
//     clk          core clock
//     we           write enable
//     waddr/wdata  write address / data (written on the rising edge)
//     raddr/rdata  read address / data (asynchronous read, so the head
//                  entry is visible the cycle after it is written)
//   Contents are not reset; validity is tracked by the owner.
// ---------------------------------------------------------------------------
module ctrl_upd_fifo_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 71,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ctrl_update_queue.sv
// ---------------------------------------------------------------------------
// ctrl_update_queue
//   In-order FIFO between the control-pipe writeback stage and the
//   branch-predictor/BTB/CTI-queue update port. Writeback cannot stall, so
//   pushes into a full queue (with no simultaneous pop) are dropped and a
//   sticky overflow flag is raised.
//
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     exeCtrl*_i, exeCtiID_i     resolved result; exeCtrlValid_i = push
//     upd*_o, updCtiID_o         head entry payload
//     updValid_o / updReady_i    update-port handshake
//     count_o                    occupancy 0..DEPTH
//     almostFull_o               count_o >= AFULL_TH
//     overflow_o                 sticky: a push was dropped
//
//   Optional build macro CTRL_UPDQ_STATS_EN adds:
//     takenCnt_o [31:0]          accepted pushes with exeCtrlDir_i = 1
//     dropCnt_o  [15:0]          dropped pushes, saturating
// ---------------------------------------------------------------------------
module ctrl_update_queue
  import ctrl_update_queue_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int PC_W     = SIZE_PC,
  parameter int TYPE_W   = BRANCH_TYPE,
  parameter int CTI_W    = SIZE_CTI_LOG,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic [PC_W-1:0]          exeCtrlPC_i,
  input  logic [TYPE_W-1:0]        exeCtrlType_i,
  input  logic                     exeCtrlValid_i,
  input  logic [PC_W-1:0]          exeCtrlNPC_i,
  input  logic                     exeCtrlDir_i,
  input  logic [CTI_W-1:0]         exeCtiID_i,

  output logic [PC_W-1:0]          updPC_o,
  output logic [TYPE_W-1:0]        updType_o,
  output logic [PC_W-1:0]          updNPC_o,
  output logic                     updDir_o,
  output logic [CTI_W-1:0]         updCtiID_o,
  output logic                     updValid_o,
  input  logic                     updReady_i,

  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     almostFull_o,
  output logic                     overflow_o
`ifdef CTRL_UPDQ_STATS_EN
  ,
  output logic [31:0]              takenCnt_o,
  output logic [15:0]              dropCnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

  logic [AW-1:0] headPtr_reg, headPtr_next;
  logic [AW-1:0] tailPtr_reg, tailPtr_next;
  logic [CW-1:0] count_reg,   count_next;
  logic          overflow_reg, overflow_next;

  logic      isFull;
  logic      popEn;
  logic      pushEn;
  logic      pushDrop;
  ctrlUpdPkt wrPkt;
  ctrlUpdPkt headPkt;

  // Handshake qualification. A pop frees the head slot in the same edge, so
  // a push into a full queue is still accepted when the consumer is ready.
  assign isFull   = (count_reg == DEPTH_C);
  assign popEn    = updValid_o & updReady_i;
  assign pushEn   = exeCtrlValid_i & (~isFull | popEn);
  assign pushDrop = exeCtrlValid_i & isFull & ~popEn;

  always_comb begin
    wrPkt          = '0;
    wrPkt.pc       = exeCtrlPC_i;
    wrPkt.ctrlType = exeCtrlType_i;
    wrPkt.nextPC   = exeCtrlNPC_i;
    wrPkt.ctrlDir  = exeCtrlDir_i;
    wrPkt.ctiID    = exeCtiID_i;
  end

  ctrl_upd_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (CTRL_UPD_PKT_SIZE),
    .AW    (AW)
  ) fifoRam (
    .clk   (clk),
    .we    (pushEn),
    .waddr (tailPtr_reg),
    .wdata (wrPkt),
    .raddr (headPtr_reg),
    .rdata (headPkt)
  );

  always_comb begin
    headPtr_next  = headPtr_reg;
    tailPtr_next  = tailPtr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg | pushDrop;

    // Pointers are exactly AW bits wide, so +1 wraps DEPTH-1 -> 0.
    if (popEn) begin
      headPtr_next = headPtr_reg + 1'b1;
    end
    if (pushEn) begin
      tailPtr_next = tailPtr_reg + 1'b1;
    end

    unique case ({pushEn, popEn})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      headPtr_reg  <= '0;
      tailPtr_reg  <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      headPtr_reg  <= headPtr_next;
      tailPtr_reg  <= tailPtr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // All status outputs derive from registers only; no input-to-output path.
  assign updValid_o   = (count_reg != '0);
  assign count_o      = count_reg;
  assign almostFull_o = (count_reg >= AFULL_C);
  assign overflow_o   = overflow_reg;

  assign updPC_o    = headPkt.pc;
  assign updType_o  = headPkt.ctrlType;
  assign updNPC_o   = headPkt.nextPC;
  assign updDir_o   = headPkt.ctrlDir;
  assign updCtiID_o = headPkt.ctiID;

`ifdef CTRL_UPDQ_STATS_EN
  logic [31:0] takenCnt_reg, takenCnt_next;
  logic [15:0] dropCnt_reg,  dropCnt_next;

  always_comb begin
    takenCnt_next = takenCnt_reg;
    dropCnt_next  = dropCnt_reg;
    if (pushEn && exeCtrlDir_i) begin
      takenCnt_next = takenCnt_reg + 32'd1;
    end
    if (pushDrop && (dropCnt_reg != 16'hFFFF)) begin
      dropCnt_next = dropCnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      takenCnt_reg <= '0;
      dropCnt_reg  <= '0;
    end else begin
      takenCnt_reg <= takenCnt_next;
      dropCnt_reg  <= dropCnt_next;
    end
  end

  assign takenCnt_o = takenCnt_reg;
  assign dropCnt_o  = dropCnt_reg;
`endif

endmodule

// File: tb/tb_ctrl_update_queue.sv
// ---------------------------------------------------------------------------
// tb_ctrl_update_queue
//   Self-checking bench for ctrl_update_queue (DEPTH = 8). Inputs are driven
//   1 time unit after the rising edge; outputs are checked on the falling
//   edge. Accepted pushes enter an expected-entry queue and are popped and
//   compared when the DUT completes a handshake. A short vector table covers
//   the single-push latency case; hand-written sequences cover fill, overflow,
//   full push+pop, wrap-around and reset mid-drain.
// ---------------------------------------------------------------------------
module tb_ctrl_update_queue;

  localparam int DEPTH    = 8;
  localparam int AFULL_TH = DEPTH - 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] exeCtrlPC_i;
  logic [1:0]  exeCtrlType_i;
  logic        exeCtrlValid_i;
  logic [31:0] exeCtrlNPC_i;
  logic        exeCtrlDir_i;
  logic [3:0]  exeCtiID_i;
  logic [31:0] updPC_o;
  logic [1:0]  updType_o;
  logic [31:0] updNPC_o;
  logic        updDir_o;
  logic [3:0]  updCtiID_o;
  logic        updValid_o;
  logic        updReady_i;
  logic [3:0]  count_o;
  logic        almostFull_o;
  logic        overflow_o;
`ifdef CTRL_UPDQ_STATS_EN
  logic [31:0] takenCnt_o;
  logic [15:0] dropCnt_o;
`endif

  always #5 clk = ~clk;

  ctrl_update_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .exeCtrlPC_i    (exeCtrlPC_i),
    .exeCtrlType_i  (exeCtrlType_i),
    .exeCtrlValid_i (exeCtrlValid_i),
    .exeCtrlNPC_i   (exeCtrlNPC_i),
    .exeCtrlDir_i   (exeCtrlDir_i),
    .exeCtiID_i     (exeCtiID_i),
    .updPC_o        (updPC_o),
    .updType_o      (updType_o),
    .updNPC_o       (updNPC_o),
    .updDir_o       (updDir_o),
    .updCtiID_o     (updCtiID_o),
    .updValid_o     (updValid_o),
    .updReady_i     (updReady_i),
    .count_o        (count_o),
    .almostFull_o   (almostFull_o),
    .overflow_o     (overflow_o)
`ifdef CTRL_UPDQ_STATS_EN
    ,
    .takenCnt_o     (takenCnt_o),
    .dropCnt_o      (dropCnt_o)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [1:0]  ty;
    logic        dir;
    logic [3:0]  cti;
  } entry_t;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [1:0]  ty;
    logic        dir;
    logic [3:0]  cti;
    logic        rdy;
    logic        expValid;
    logic [3:0]  expCount;
    logic [31:0] expPC;
  } vec_t;

  entry_t      expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          mCount = 0;
  logic        mOvf   = 1'b0;
  int unsigned mTaken = 0;
  int unsigned mDrop  = 0;
  logic        sawDead = 1'b0;
  int          txn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge against
  // the reference model, then advance the model across the rising edge.
  task automatic doCycle(input logic rst, input logic v, input logic [31:0] pc,
                         input logic [31:0] npc, input logic [1:0] ty,
                         input logic dir, input logic [3:0] cti, input logic rdy);
    logic popM;
    logic accM;
    entry_t e;
    reset          = rst;
    exeCtrlValid_i = v;
    exeCtrlPC_i    = pc;
    exeCtrlNPC_i   = npc;
    exeCtrlType_i  = ty;
    exeCtrlDir_i   = dir;
    exeCtiID_i     = cti;
    updReady_i     = rdy;
    @(negedge clk);
    chk("count", 32'(count_o), 32'(mCount));
    chk("updValid", 32'(updValid_o), 32'(mCount != 0));
    chk("almostFull", 32'(almostFull_o), 32'(mCount >= AFULL_TH));
    chk("overflow", 32'(overflow_o), 32'(mOvf));
`ifdef CTRL_UPDQ_STATS_EN
    chk("takenCnt", takenCnt_o, mTaken);
    chk("dropCnt", 32'(dropCnt_o), mDrop);
`endif
    if (updValid_o === 1'b1 && updPC_o === 32'hDEAD) sawDead = 1'b1;
    if (!rst && rdy && updValid_o === 1'b1) begin
      if (expQ.size() == 0) begin
        chk("unexpectedPop", 32'(updValid_o), 32'd0);
      end else begin
        e = expQ.pop_front();
        chk("updPC", updPC_o, e.pc);
        chk("updNPC", updNPC_o, e.npc);
        chk("updType", 32'(updType_o), 32'(e.ty));
        chk("updDir", 32'(updDir_o), 32'(e.dir));
        chk("updCtiID", 32'(updCtiID_o), 32'(e.cti));
        $display("txn %0d: pop pc=0x%0h npc=0x%0h count=%0d", txn, updPC_o, updNPC_o, count_o);
        txn++;
      end
    end
    if (rst) begin
      expQ.delete();
      mCount = 0;
      mOvf   = 1'b0;
      mTaken = 0;
      mDrop  = 0;
    end else begin
      popM = (mCount != 0) && rdy;
      accM = v && ((mCount < DEPTH) || popM);
      if (accM) begin
        e.pc = pc; e.npc = npc; e.ty = ty; e.dir = dir; e.cti = cti;
        expQ.push_back(e);
        if (dir) mTaken++;
      end
      if (v && !accM) begin
        mOvf = 1'b1;
        if (mDrop != 32'hFFFF) mDrop++;
      end
      mCount = mCount + int'(accM) - int'(popM);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    doCycle(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 4'd0, rdy);
  endtask

  vec_t vecs[3];

  initial begin
    reset = 1'b1;
    exeCtrlValid_i = 1'b0;
    exeCtrlPC_i = '0; exeCtrlNPC_i = '0; exeCtrlType_i = '0;
    exeCtrlDir_i = 1'b0; exeCtiID_i = '0; updReady_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single push with consumer ready: visible exactly one cycle later.
    vecs[0] = '{1'b0, 1'b1, 32'h1000, 32'h1040, 2'd2, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h0,    32'h0,    2'd0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 32'h1000};
    vecs[2] = '{1'b0, 1'b0, 32'h0,    32'h0,    2'd0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 32'h0};
    for (int i = 0; i < 3; i++) begin
      fork
        begin
          @(negedge clk);
          chk("vecValid", 32'(updValid_o), 32'(vecs[i].expValid));
          chk("vecCount", 32'(count_o), 32'(vecs[i].expCount));
          if (vecs[i].expValid) chk("vecPC", updPC_o, vecs[i].expPC);
        end
      join_none
      doCycle(vecs[i].rst, vecs[i].valid, vecs[i].pc, vecs[i].npc, vecs[i].ty,
              vecs[i].dir, vecs[i].cti, vecs[i].rdy);
    end

    // Fill 8 entries with consumer stalled.
    for (int i = 0; i < DEPTH; i++)
      doCycle(1'b0, 1'b1, 32'h100 + 32'(i), 32'h2000 + 32'(i), 2'(i), 1'(i), 4'(i), 1'b0);
    idle(1'b0);
    // Full, stalled: 0xDEAD is dropped.
    doCycle(1'b0, 1'b1, 32'hDEAD, 32'hBEEF, 2'd1, 1'b1, 4'd9, 1'b0);
    idle(1'b0);
    // Full with simultaneous pop: 0x200 accepted, lands behind older entries.
    doCycle(1'b0, 1'b1, 32'h200, 32'h240, 2'd3, 1'b0, 4'd7, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    chk("deadNeverSeen", 32'(sawDead), 32'd0);

    // Continuous push + pop across pointer wrap.
    doCycle(1'b0, 1'b1, 32'h300, $urandom, 2'($urandom), 1'($urandom), 4'($urandom), 1'b0);
    for (int i = 1; i <= 20; i++)
      doCycle(1'b0, 1'b1, 32'h300 + 32'(i), $urandom, 2'($urandom), 1'($urandom), 4'($urandom), 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Stats scenario after reset: 3 taken pushes, then 2 drops when full.
    doCycle(1'b1, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      doCycle(1'b0, 1'b1, 32'h400 + 32'(i), 32'h500 + 32'(i), 2'd0, (i < 3), 4'(i), 1'b0);
    doCycle(1'b0, 1'b1, 32'h4F0, 32'h0, 2'd0, 1'b1, 4'd0, 1'b0);
    doCycle(1'b0, 1'b1, 32'h4F1, 32'h0, 2'd0, 1'b0, 4'd0, 1'b0);
    idle(1'b0);
`ifdef CTRL_UPDQ_STATS_EN
    chk("takenCnt3", takenCnt_o, 32'd3);
    chk("dropCnt2", 32'(dropCnt_o), 32'd2);
`endif

    // Reset mid-drain with 5 entries queued.
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("fiveQueued", 32'(count_o), 32'd5);
    doCycle(1'b1, 1'b1, 32'h600, 32'h0, 2'd0, 1'b1, 4'd0, 1'b1);
    chk("rstValid", 32'(updValid_o), 32'd0);
    chk("rstCount", 32'(count_o), 32'd0);
    chk("rstOverflow", 32'(overflow_o), 32'd0);
    idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
